mips_multicycle_ctrl: RTL and testbench
=======================================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters; all encodings are fixed constants.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for the state register.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 opcode  in  6  instr[31:26], held stable by the instruction register after FETCH.
REQ-006 funct  in  6  instr[5:0].
REQ-007 zero  in  1  Zero flag from the 32-bit ALU, same cycle.
REQ-008 alu_control  out  4  ALU op: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
REQ-009 alu_src_a  out  1  0 = PC, 1 = register A.
REQ-010 alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
REQ-011 pc_src  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
REQ-012 pc_en  out  1  PC load enable.
REQ-013 iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg  out  1 each  datapath strobes and selects.
REQ-014 state  out  4  current state, for debug.

Function
REQ-015 The block SHALL be a Moore FSM; every output except pc_en SHALL decode from the registered state only.
REQ-016 pc_en SHALL equal pc_write | (branch & zero), combinationally; branch is an internal Moore signal.
REQ-017 The states SHALL be FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
REQ-018 FETCH SHALL assert ir_write and pc_write with alu_src_a=0, alu_src_b=01, ADD, and go to DECODE.
REQ-019 DECODE SHALL drive alu_src_a=0, alu_src_b=11, ADD, and branch on opcode: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP, any other -> FETCH (executed as NOP).
REQ-020 MEMADR (src_a=1, src_b=10, ADD) SHALL go to MEMRD for lw and to MEMWR for sw.
REQ-021 Transitions: MEMRD(iord=1) -> MEMWB(reg_write, mem_to_reg=1, reg_dst=0) -> FETCH; MEMWR(iord=1, mem_write) -> FETCH.
REQ-022 EXEC (src_a=1, src_b=00, funct-decoded op) -> ALUWB(reg_write, reg_dst=1) -> FETCH.
REQ-023 BRANCH (src_a=1, src_b=00, SUB, branch=1, pc_src=01) -> FETCH; PC SHALL load only if zero=1 in that cycle.
REQ-024 ADDIEX (src_a=1, src_b=10, ADD) -> ADDIWB(reg_write, reg_dst=0) -> FETCH; JUMP (pc_write, pc_src=10) -> FETCH.
REQ-025 Funct decode in EXEC: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR; any other funct SHALL give 1111, which the ALU returns as 0.
REQ-026 Latency in cycles from FETCH to the next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown opcode 2.
REQ-027 Every strobe not named for a state SHALL be 0; alu_control defaults to ADD.

Reset
REQ-028 On a rising edge with rst_n=0 the state SHALL become FETCH, including mid-instruction.
REQ-029 While rst_n=0, pc_en, ir_write, mem_write and reg_write SHALL be forced to 0; the other outputs follow FETCH decode.
REQ-030 The first FETCH after rst_n rises SHALL be a normal FETCH that asserts ir_write and pc_en.

Structure
REQ-031 State encodings, opcode and funct constants, and ALU control codes SHALL live in a shared package, mips_ctrl_pkg; the ALU uses the same control codes.
REQ-032 Funct-to-ALU-op decode SHALL be one combinational sub-module, alu_decoder (inputs alu_op[1:0] and funct; output alu_control).
REQ-033 The state register SHALL be the only storage in the block.

Verification
REQ-034 Reset, then opcode=100011 -> states 0,1,2,3,4,0; reg_write=1 only in state 4, with mem_to_reg=1.
REQ-035 opcode=000000, funct=101010 -> alu_control=0111 in EXEC; reg_write and reg_dst=1 in ALUWB; back to FETCH 4 cycles after the start.
REQ-036 opcode=000100 with zero=1 in BRANCH -> pc_en=1, pc_src=01; repeat with zero=0 -> pc_en=0; both return to FETCH after 3 cycles.
REQ-037 opcode=111111 -> FETCH, DECODE, FETCH; mem_write and reg_write never assert.
REQ-038 rst_n=0 for one edge while in MEMWR -> next state FETCH; mem_write=0 during the reset cycle.
REQ-039 Sweep all six legal functs plus 000000 -> alu_control matches the REQ-025 table, and 1111 for the illegal funct.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode, funct and ALU control encodings for the multicycle MIPS controller
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_BAD = 4'b1111;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the controller's ALU op class and the R-type funct field to an ALU control code
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_control
);
  // fixed ops for address/branch arithmetic, funct lookup otherwise; unknown functs give a code the ALU treats as 0
  always_comb
    alu_control = alu_op == ALUOP_ADD ? ALU_ADD :
                  alu_op == ALUOP_SUB ? ALU_SUB :
                  funct == F_ADD ? ALU_ADD :
                  funct == F_SUB ? ALU_SUB :
                  funct == F_AND ? ALU_AND :
                  funct == F_OR  ? ALU_OR  :
                  funct == F_SLT ? ALU_SLT :
                  funct == F_NOR ? ALU_NOR : ALU_BAD;
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore control FSM for a multicycle MIPS datapath (lw, sw, R-type, beq, addi, j)
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [3:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       iord,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [3:0] state
);
  state_t st;
  state_t ds;
  logic [1:0] alu_op;
  logic pc_write, branch, ir_w, mem_w, reg_w;
  assign state = st;
  // while reset is held the outputs look like FETCH, so the datapath sees a quiet, predictable decode
  assign ds = rst_n ? st : S_FETCH;
  // state register with next-state selection
  always_ff @(posedge clk)
    if (!rst_n) st <= S_FETCH;
    else
      case (st)
        S_FETCH:  st <= S_DECODE;
        S_DECODE: st <= (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                        opcode == OP_RTYPE ? S_EXEC :
                        opcode == OP_BEQ ? S_BRANCH :
                        opcode == OP_ADDI ? S_ADDIEX :
                        opcode == OP_J ? S_JUMP : S_FETCH;
        S_MEMADR: st <= opcode == OP_LW ? S_MEMRD : S_MEMWR;
        S_MEMRD:  st <= S_MEMWB;
        S_EXEC:   st <= S_ALUWB;
        S_ADDIEX: st <= S_ADDIWB;
        default:  st <= S_FETCH;
      endcase
  // Moore output decode from the state alone
  always_comb begin
    alu_op = ALUOP_ADD;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    pc_src = 2'b00;
    pc_write = 1'b0;
    branch = 1'b0;
    iord = 1'b0;
    ir_w = 1'b0;
    mem_w = 1'b0;
    reg_w = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    case (ds)
      S_FETCH:  begin ir_w = 1'b1; pc_write = 1'b1; alu_src_b = 2'b01; end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_MEMRD:  iord = 1'b1;
      S_MEMWB:  begin reg_w = 1'b1; mem_to_reg = 1'b1; end
      S_MEMWR:  begin iord = 1'b1; mem_w = 1'b1; end
      S_EXEC:   begin alu_src_a = 1'b1; alu_op = ALUOP_FUNCT; end
      S_ALUWB:  begin reg_w = 1'b1; reg_dst = 1'b1; end
      S_BRANCH: begin alu_src_a = 1'b1; alu_op = ALUOP_SUB; branch = 1'b1; pc_src = 2'b01; end
      S_ADDIEX: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_ADDIWB: reg_w = 1'b1;
      S_JUMP:   begin pc_write = 1'b1; pc_src = 2'b10; end
      default:  ;
    endcase
  end
  assign pc_en = rst_n & (pc_write | (branch & zero));
  assign ir_write = rst_n & ir_w;
  assign mem_write = rst_n & mem_w;
  assign reg_write = rst_n & reg_w;
  alu_decoder u_dec (
    .alu_op(alu_op),
    .funct(funct),
    .alu_control(alu_control)
  );
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: random and directed instruction streams checked against a per-instruction cycle model
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] opcode, funct;
  logic zero;
  logic [3:0] alu_control, state;
  logic alu_src_a, pc_en, iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg;
  logic [1:0] alu_src_b, pc_src;
  int vectors = 0;
  int miscompares = 0;
  logic [5:0] fn_tab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
  logic [3:0] code_tab [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};
  logic [5:0] op_tab [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .pc_en(pc_en), .iord(iord), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .state(state)
  );

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] dut_vec();
    return {state, alu_control, alu_src_a, alu_src_b, pc_src, pc_en, iord, ir_write,
            mem_write, reg_write, reg_dst, mem_to_reg};
  endfunction

  function automatic logic [3:0] funct_code(input logic [5:0] fn);
    for (int i = 0; i < 6; i++) if (fn_tab[i] == fn) return code_tab[i];
    return 4'b1111;
  endfunction

  // what each step of an instruction must drive, written as the datapath's action for that step
  function automatic logic [19:0] model_out(input int s, input logic [5:0] fn, input logic z);
    logic [3:0] aluc;
    logic sa, pe, io, irw, mw, rw, rd, m2r;
    logic [1:0] sb, ps;
    aluc = s == 6 ? funct_code(fn) : s == 8 ? 4'b0110 : 4'b0010;
    sa = (s == 2 || s == 6 || s == 8 || s == 9);
    sb = s == 0 ? 2'b01 : s == 1 ? 2'b11 : (s == 2 || s == 9) ? 2'b10 : 2'b00;
    ps = s == 8 ? 2'b01 : s == 11 ? 2'b10 : 2'b00;
    pe = (s == 0 || s == 11) || (s == 8 && z);
    io = (s == 3 || s == 5);
    irw = s == 0;
    mw = s == 5;
    rw = (s == 4 || s == 7 || s == 10);
    rd = s == 7;
    m2r = s == 4;
    return {4'(s), aluc, sa, sb, ps, pe, io, irw, mw, rw, rd, m2r};
  endfunction

  // runs one instruction from FETCH; rst_at >= 0 pulls reset at that step instead of finishing
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int zmode, input int rst_at);
    int path[$];
    path = {0, 1};
    if (op == 6'b100011) path = {path, 2, 3, 4};
    else if (op == 6'b101011) path = {path, 2, 5};
    else if (op == 6'b000000) path = {path, 6, 7};
    else if (op == 6'b000100) path.push_back(8);
    else if (op == 6'b001000) path = {path, 9, 10};
    else if (op == 6'b000010) path.push_back(11);
    opcode = op;
    funct = fn;
    foreach (path[k]) begin
      zero = zmode == 2 ? 1'($urandom_range(0, 1)) : (zmode == 1);
      if (k == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        check($sformatf("%s_rst_outs", name),
              {9'b0, pc_en, ir_write, mem_write, reg_write, alu_src_a, alu_src_b, alu_control},
              {9'b0, 4'b0000, 1'b0, 2'b01, 4'b0010});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check($sformatf("%s_rst_state", name), {16'b0, state}, 20'd0);
        return;
      end
      @(negedge clk);
      check($sformatf("%s_op%b_fn%b_step%0d", name, op, fn, k), dut_vec(), model_out(path[k], fn, zero));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 6'b000000;
    funct = 6'b000000;
    zero = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_hold", {9'b0, pc_en, ir_write, mem_write, reg_write, alu_src_a, alu_src_b, alu_control},
          {9'b0, 4'b0000, 1'b0, 2'b01, 4'b0010});
    check("reset_state", {16'b0, state}, 20'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr("lw", 6'b100011, 6'b000000, 2, -1);
    run_instr("slt", 6'b000000, 6'b101010, 2, -1);
    run_instr("beq_taken", 6'b000100, 6'b000000, 1, -1);
    run_instr("beq_not", 6'b000100, 6'b000000, 0, -1);
    run_instr("nop", 6'b111111, 6'b000000, 2, -1);
    run_instr("sw_rst", 6'b101011, 6'b000000, 2, 3);
    run_instr("after_rst", 6'b001000, 6'b000000, 2, -1);
    for (int i = 0; i < 6; i++) run_instr("sweep", 6'b000000, fn_tab[i], 2, -1);
    run_instr("sweep_bad", 6'b000000, 6'b000000, 2, -1);
    run_instr("j", 6'b000010, 6'b000000, 2, -1);
    run_instr("sw", 6'b101011, 6'b000000, 2, -1);
    for (int i = 0; i < 120; i++) begin
      logic [5:0] op, fn;
      int ra;
      op = $urandom_range(0, 6) == 6 ? 6'($urandom) : op_tab[$urandom_range(0, 5)];
      fn = $urandom_range(0, 1) == 1 ? fn_tab[$urandom_range(0, 5)] : 6'($urandom);
      ra = $urandom_range(0, 7) == 0 ? int'($urandom_range(0, 4)) : -1;
      run_instr("rand", op, fn, 2, ra);
    end
    zero = 1'b0;
    @(negedge clk);
    check("final_fetch", dut_vec(), model_out(0, funct, 1'b0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
